rtc_bcd_clock: RTL and testbench
================================

# rtc_bcd_clock

Parameterised real-time clock core for the display subsystem: divides the system clock to a 1 Hz time base and keeps hours, minutes and seconds directly in BCD digits. Adds the features the fixed 24-hour counter lacked:

- configurable input frequency,
- run/pause,
- validated time load,
- 12/24-hour display mode with PM flag,
- one programmable daily alarm with sticky flag and acknowledge.

Digit outputs drive the seven-segment decoders directly.

## Interface

- TICKS_PER_SEC, default 50_000_000: clk cycles per second; legal range is ≥ 2. Prescaler width is clog2(TICKS_PER_SEC).

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- run  in  1  1 = prescaler counts; 0 = prescaler and time hold
- mode_12h  in  1  0 = 24-hour display; 1 = 12-hour display
- load  in  1  one-cycle request to load load_time
- load_time  in  24  BCD {hour_tens[23:20], hour_ones, min_tens, min_ones, sec_tens, sec_ones}, always in 24-hour form
- alarm_wr  in  1  one-cycle request to write alarm_time
- alarm_time  in  16  BCD {hour_tens, hour_ones, min_tens, min_ones}, 24-hour form
- alarm_en  in  1  alarm match enable
- alarm_ack  in  1  clears alarm
- sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens  out  4 each  displayed BCD digits
- pm  out  1  1 when internal hour ≥ 12, in either mode
- tick  out  1  one-cycle pulse, coincident with each new second value
- alarm  out  1  sticky alarm flag
- load_err  out  1  one-cycle pulse on a rejected load or alarm_wr

## Operation

**Internal state**
- The six BCD time digits are always kept in 24-hour form.
- Alarm register holds hh:mm.
- Prescaler counts 0..TICKS_PER_SEC-1.

**Prescaler and tick**
- Prescaler advances only when run=1.
- On the edge where the prescaler equals TICKS_PER_SEC-1, it returns to 0 and the time increments by one second.
- tick is registered and is high for the cycle after that edge.

**Time increment**
- BCD carry chain: sec_ones 9→0 carries into sec_tens; sec_tens 5→0 carries into minutes.
- Minutes follow the same rule and carry into hours.
- Hours 23→00.
- 23:59:59 → 00:00:00.

**Load**
- Valid when every digit ≤ 9, sec_tens ≤ 5, min_tens ≤ 5 and hour ≤ 23.
- A valid load writes the time and clears the prescaler to 0 on the next edge.
- Load has priority over a same-cycle increment; no tick is issued for that cycle.
- An invalid load leaves time and prescaler unchanged and pulses load_err.

**Alarm write**
- Same digit checks as load (hour ≤ 23, minutes ≤ 59).
- A valid write updates the alarm register.
- An invalid write is ignored and pulses load_err.

**Alarm match**
- alarm sets on the increment edge whose result equals alarm hh:mm:00, provided alarm_en=1.
- Loading a matching time never sets alarm.
- alarm stays high until alarm_ack.
- If set and alarm_ack occur in the same cycle, set wins.
- A later alarm_en=0 does not clear an already-set flag.

**Display mapping** (combinational from registers and mode_12h)
- mode_12h=0: digits are the internal digits.
- mode_12h=1:
  - hour 00 → 12;
  - hours 01–12 unchanged;
  - hours 13–23 → hour − 12, in BCD (e.g. 20 → 08).
- Minutes and seconds are unchanged in either mode.
- pm is independent of mode.

## Timing

**Reset** (asynchronous, takes effect immediately)
- Prescaler = 0, time = 00:00:00, alarm register = 00:00.
- tick = alarm = load_err = 0, pm = 0.
- Digits are 0, except hour_tens=1 and hour_ones=2 when mode_12h=1.
- Reset asserted mid-second discards the partial second.

**Latency**
- load / alarm_wr: result is visible 1 cycle after the request edge.
- load_err is high in that same following cycle.
- mode_12h: display changes in the same cycle, with no register delay.

**Timing relations**
- First tick after reset or a valid load with run=1: exactly TICKS_PER_SEC cycles after the edge that cleared the prescaler.
- run=0 freezes the prescaler at its current value; resuming continues the partial second with no loss.
- load and alarm_wr in the same cycle: both are independent and both are applied. A newly written alarm value is compared from the next increment onward.

## Test plan

All scenarios use TICKS_PER_SEC=4.

- **Free run:** reset, run=1 for 960 cycles → display 00:04:00; tick every 4th cycle; 240 ticks total.
- **Midnight wrap:** load 23:59:59, run 4 cycles → 00:00:00; pm goes 1→0; tick pulses once.
- **12-hour mode:** mode_12h=1, load 00:30:00 → display 12:30:00, pm=0. Load 13:05:00 → display 01:05:00, pm=1. Set mode_12h=0 → display 13:05:00 in the same cycle.
- **Invalid load:** load 24:00:00, then 12:60:00, then 0A:00:00 → load_err pulses each time; time unchanged.
- **Alarm:** alarm_wr 07:00, alarm_en=1, load 06:59:59, 4 cycles → alarm=1 with display 07:00:00. alarm_ack → alarm=0. Load 07:00:00 directly → alarm stays 0. ack and match in the same cycle → alarm=1.
- **Pause and reset:** run=0 for 10 cycles after 2 prescaler counts → time frozen; after run=1, next tick arrives 2 cycles later. Assert reset asynchronously mid-second → all outputs return to reset values before the next clk edge.

Source files
------------

// File: rtl/rtc_bcd_clock.sv
// rtc_bcd_clock
// Real-time clock core. Divides clk down to a 1 Hz time base and keeps
// hh:mm:ss as six BCD digits, always in 24-hour form internally. It also
// holds one daily hh:mm alarm with a sticky flag, and maps the hours to
// 12-hour form for display when mode_12h is set.
//
// Ports
//   clk, reset            system clock; asynchronous active-high reset
//   run                   1 = prescaler counts, 0 = prescaler and time hold
//   mode_12h              0 = 24-hour display, 1 = 12-hour display
//   load, load_time       one-cycle request to load a BCD hhmmss (24-hour form)
//   alarm_wr, alarm_time  one-cycle request to write a BCD hhmm alarm
//   alarm_en, alarm_ack   alarm match enable; clear for the sticky alarm flag
//   sec_*/min_*/hour_*    displayed BCD digits
//   pm                    internal hour >= 12, in either display mode
//   tick                  one-cycle pulse with each new second value
//   alarm                 sticky alarm flag
//   load_err              one-cycle pulse on a rejected load or alarm_wr
module rtc_bcd_clock #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        mode_12h,
  input  logic        load,
  input  logic [23:0] load_time,
  input  logic        alarm_wr,
  input  logic [15:0] alarm_time,
  input  logic        alarm_en,
  input  logic        alarm_ack,
  output logic [3:0]  sec_ones,
  output logic [3:0]  sec_tens,
  output logic [3:0]  min_ones,
  output logic [3:0]  min_tens,
  output logic [3:0]  hour_ones,
  output logic [3:0]  hour_tens,
  output logic        pm,
  output logic        tick,
  output logic        alarm,
  output logic        load_err
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);

  // hh:mm in BCD: digits decimal, minute tens at most 5, hour at most 23.
  function automatic logic hhmm_ok(input logic [15:0] t);
    logic hour_ok;
    hour_ok = ((t[15:12] <= 4'd1) && (t[11:8] <= 4'd9)) ||
              ((t[15:12] == 4'd2) && (t[11:8] <= 4'd3));
    return hour_ok && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
  endfunction

  // hh:mm:ss in BCD: hh:mm rules plus second tens at most 5.
  function automatic logic hhmmss_ok(input logic [23:0] t);
    return hhmm_ok(t[23:8]) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
  endfunction

  logic [PW-1:0] prescale_r;
  logic [3:0]    sec_ones_r, sec_tens_r, min_ones_r, min_tens_r;
  logic [3:0]    hour_ones_r, hour_tens_r;
  logic [15:0]   alarm_hhmm_r;
  logic          tick_r, alarm_r, load_err_r;

  logic          wrap_s, load_ok_s, alarm_ok_s, load_take_s, set_s;
  logic          so_c_s, st_c_s, mo_c_s, mt_c_s, hour_last_s;
  logic [3:0]    n_so_s, n_st_s, n_mo_s, n_mt_s, n_ho_s, n_ht_s;
  logic [4:0]    hour_bin_s, h12_s;
  logic [3:0]    disp_ht_s, disp_ho_s;

  assign wrap_s      = run && (prescale_r == PRE_LAST);
  assign load_ok_s   = hhmmss_ok(load_time);
  assign alarm_ok_s  = hhmm_ok(alarm_time);
  assign load_take_s = load && load_ok_s;

  // Next-second value: BCD carry chain through seconds, minutes, hours.
  always_comb begin
    so_c_s      = (sec_ones_r == 4'd9);
    st_c_s      = so_c_s && (sec_tens_r == 4'd5);
    mo_c_s      = st_c_s && (min_ones_r == 4'd9);
    mt_c_s      = mo_c_s && (min_tens_r == 4'd5);
    hour_last_s = (hour_tens_r == 4'd2) && (hour_ones_r == 4'd3);
    n_so_s = so_c_s ? 4'd0 : sec_ones_r + 4'd1;
    n_st_s = !so_c_s ? sec_tens_r : (st_c_s ? 4'd0 : sec_tens_r + 4'd1);
    n_mo_s = !st_c_s ? min_ones_r : (mo_c_s ? 4'd0 : min_ones_r + 4'd1);
    n_mt_s = !mo_c_s ? min_tens_r : (mt_c_s ? 4'd0 : min_tens_r + 4'd1);
    if (!mt_c_s) begin
      n_ho_s = hour_ones_r;
      n_ht_s = hour_tens_r;
    end else if (hour_last_s) begin
      n_ho_s = 4'd0;
      n_ht_s = 4'd0;
    end else if (hour_ones_r == 4'd9) begin
      n_ho_s = 4'd0;
      n_ht_s = hour_tens_r + 4'd1;
    end else begin
      n_ho_s = hour_ones_r + 4'd1;
      n_ht_s = hour_tens_r;
    end
  end

  // Alarm fires only on a real increment landing on hh:mm:00, never on a load.
  assign set_s = wrap_s && !load_take_s && alarm_en &&
                 ({n_ht_s, n_ho_s, n_mt_s, n_mo_s} == alarm_hhmm_r) &&
                 (n_st_s == 4'd0) && (n_so_s == 4'd0);

  // Hour display mapping; 12-hour values 1..12 fit in one tens digit of 0/1.
  always_comb begin
    hour_bin_s = {1'b0, hour_tens_r} * 5'd10 + {1'b0, hour_ones_r};
    if (hour_bin_s == 5'd0) begin
      h12_s = 5'd12;
    end else if (hour_bin_s > 5'd12) begin
      h12_s = hour_bin_s - 5'd12;
    end else begin
      h12_s = hour_bin_s;
    end
    if (!mode_12h) begin
      disp_ht_s = hour_tens_r;
      disp_ho_s = hour_ones_r;
    end else if (h12_s >= 5'd10) begin
      disp_ht_s = 4'd1;
      disp_ho_s = h12_s[3:0] - 4'd10;
    end else begin
      disp_ht_s = 4'd0;
      disp_ho_s = h12_s[3:0];
    end
  end

  // Prescaler, time, alarm register and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_r   <= '0;
      sec_ones_r   <= 4'd0;
      sec_tens_r   <= 4'd0;
      min_ones_r   <= 4'd0;
      min_tens_r   <= 4'd0;
      hour_ones_r  <= 4'd0;
      hour_tens_r  <= 4'd0;
      alarm_hhmm_r <= 16'h0000;
      tick_r       <= 1'b0;
      alarm_r      <= 1'b0;
      load_err_r   <= 1'b0;
    end else begin
      load_err_r <= (load && !load_ok_s) || (alarm_wr && !alarm_ok_s);
      // A rejected load is simply ignored; counting carries on as usual.
      if (load_take_s) begin
        prescale_r  <= '0;
        hour_tens_r <= load_time[23:20];
        hour_ones_r <= load_time[19:16];
        min_tens_r  <= load_time[15:12];
        min_ones_r  <= load_time[11:8];
        sec_tens_r  <= load_time[7:4];
        sec_ones_r  <= load_time[3:0];
        tick_r      <= 1'b0;
      end else if (wrap_s) begin
        prescale_r  <= '0;
        hour_tens_r <= n_ht_s;
        hour_ones_r <= n_ho_s;
        min_tens_r  <= n_mt_s;
        min_ones_r  <= n_mo_s;
        sec_tens_r  <= n_st_s;
        sec_ones_r  <= n_so_s;
        tick_r      <= 1'b1;
      end else if (run) begin
        prescale_r  <= prescale_r + PRE_ONE;
        tick_r      <= 1'b0;
      end else begin
        tick_r      <= 1'b0;
      end
      if (alarm_wr && alarm_ok_s) begin
        alarm_hhmm_r <= alarm_time;
      end
      // Set beats a same-cycle acknowledge.
      if (set_s) begin
        alarm_r <= 1'b1;
      end else if (alarm_ack) begin
        alarm_r <= 1'b0;
      end
    end
  end

  assign sec_ones  = sec_ones_r;
  assign sec_tens  = sec_tens_r;
  assign min_ones  = min_ones_r;
  assign min_tens  = min_tens_r;
  assign hour_ones = disp_ho_s;
  assign hour_tens = disp_ht_s;
  assign pm        = (hour_bin_s >= 5'd12);
  assign tick      = tick_r;
  assign alarm     = alarm_r;
  assign load_err  = load_err_r;

endmodule

// File: tb/tb_rtc_bcd_clock.sv
// Testbench for rtc_bcd_clock with TICKS_PER_SEC = 4. A reference model keeps
// time as seconds-of-day and the alarm as minutes-of-day, and every cycle the
// DUT outputs are compared against it; directed scenarios are followed by a
// randomized phase.
module tb_rtc_bcd_clock;
  localparam int TPS = 4;

  logic        clk = 1'b0;
  logic        reset, run, mode_12h, load, alarm_wr, alarm_en, alarm_ack;
  logic [23:0] load_time;
  logic [15:0] alarm_time;
  logic [3:0]  sec_ones, sec_tens, min_ones, min_tens, hour_ones, hour_tens;
  logic        pm, tick, alarm, load_err;

  rtc_bcd_clock #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .reset(reset), .run(run), .mode_12h(mode_12h),
    .load(load), .load_time(load_time), .alarm_wr(alarm_wr),
    .alarm_time(alarm_time), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
    .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones),
    .min_tens(min_tens), .hour_ones(hour_ones), .hour_tens(hour_tens),
    .pm(pm), .tick(tick), .alarm(alarm), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int tick_cnt = 0;

  // reference model state
  int m_secs, m_pre, m_alarm_min;
  bit m_tick, m_alarm, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit hhmm_ok(input logic [15:0] v);
    int ht = int'(v[15:12]);
    int ho = int'(v[11:8]);
    int mt = int'(v[7:4]);
    int mo = int'(v[3:0]);
    return (ht <= 9) && (ho <= 9) && (mt <= 5) && (mo <= 9) && (ht * 10 + ho <= 23);
  endfunction

  function automatic bit hhmmss_ok(input logic [23:0] v);
    return hhmm_ok(v[23:8]) && (int'(v[7:4]) <= 5) && (int'(v[3:0]) <= 9);
  endfunction

  function automatic int to_secs(input logic [23:0] v);
    return (int'(v[23:20]) * 10 + int'(v[19:16])) * 3600 +
           (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
           int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [23:0] enc(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [23:0] shown();
    return {hour_tens, hour_ones, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic model_reset();
    m_secs = 0; m_pre = 0; m_alarm_min = 0;
    m_tick = 1'b0; m_alarm = 1'b0; m_err = 1'b0;
  endtask

  // One clock edge of behaviour, from the inputs present at that edge.
  task automatic model_step();
    bit set = 1'b0;
    m_err = (load && !hhmmss_ok(load_time)) || (alarm_wr && !hhmm_ok(alarm_time));
    m_tick = 1'b0;
    if (load && hhmmss_ok(load_time)) begin
      m_secs = to_secs(load_time);
      m_pre  = 0;
    end else if (run) begin
      if (m_pre == TPS - 1) begin
        m_pre  = 0;
        m_secs = (m_secs + 1) % 86400;
        m_tick = 1'b1;
        set    = alarm_en && (m_secs == m_alarm_min * 60);
      end else begin
        m_pre = m_pre + 1;
      end
    end
    if (set) m_alarm = 1'b1;
    else if (alarm_ack) m_alarm = 1'b0;
    if (alarm_wr && hhmm_ok(alarm_time))
      m_alarm_min = (int'(alarm_time[15:12]) * 10 + int'(alarm_time[11:8])) * 60 +
                    int'(alarm_time[7:4]) * 10 + int'(alarm_time[3:0]);
  endtask

  task automatic check_outputs();
    int h  = m_secs / 3600;
    int mi = (m_secs / 60) % 60;
    int s  = m_secs % 60;
    int dh = h;
    if (mode_12h) dh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    check("digits", 32'(shown()), 32'(enc(dh, mi, s)));
    check("pm", 32'(pm), 32'(h >= 12));
    check("tick", 32'(tick), 32'(m_tick));
    check("alarm", 32'(alarm), 32'(m_alarm));
    check("load_err", 32'(load_err), 32'(m_err));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    if (tick) tick_cnt++;
    check_outputs();
  endtask

  task automatic do_load(input logic [23:0] t);
    load = 1'b1; load_time = t;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; mode_12h = 1'b0; load = 1'b0; alarm_wr = 1'b0;
    alarm_en = 1'b0; alarm_ack = 1'b0; load_time = 24'h000000; alarm_time = 16'h0000;
    #1;
    model_reset();
    check_outputs();
    cycle(); cycle();
    reset = 1'b0;

    // free run
    run = 1'b1; tick_cnt = 0;
    repeat (960) cycle();
    check("free_ticks", 32'(tick_cnt), 32'd240);
    check("free_time", 32'(shown()), 32'h000400);

    // midnight wrap
    do_load(24'h235959);
    check("pre_wrap_pm", 32'(pm), 32'd1);
    tick_cnt = 0;
    repeat (4) cycle();
    check("wrap_ticks", 32'(tick_cnt), 32'd1);
    check("wrap_time", 32'(shown()), 32'h000000);
    check("wrap_pm", 32'(pm), 32'd0);

    // 12-hour mode
    mode_12h = 1'b1;
    do_load(24'h003000);
    check("h12_midnight", 32'(shown()), 32'h123000);
    do_load(24'h130500);
    check("h12_pm_time", 32'(shown()), 32'h010500);
    check("h12_pm_flag", 32'(pm), 32'd1);
    mode_12h = 1'b0;
    #1;
    check("h24_same_cycle", 32'(shown()), 32'h130500);
    check_outputs();

    // invalid loads
    run = 1'b0;
    do_load(24'h240000);
    check("bad_hour_err", 32'(load_err), 32'd1);
    do_load(24'h126000);
    check("bad_min_err", 32'(load_err), 32'd1);
    do_load(24'h0A0000);
    check("bad_digit_err", 32'(load_err), 32'd1);
    check("bad_time_kept", 32'(shown()), 32'h130500);

    // alarm
    alarm_en = 1'b1; alarm_wr = 1'b1; alarm_time = 16'h0700;
    cycle();
    alarm_wr = 1'b0; run = 1'b1;
    do_load(24'h065959);
    repeat (4) cycle();
    check("alarm_set", 32'(alarm), 32'd1);
    check("alarm_time", 32'(shown()), 32'h070000);
    alarm_ack = 1'b1; cycle(); alarm_ack = 1'b0;
    check("alarm_ack", 32'(alarm), 32'd0);
    do_load(24'h070000);
    check("alarm_on_load", 32'(alarm), 32'd0);
    do_load(24'h065959);
    repeat (3) cycle();
    alarm_ack = 1'b1; cycle(); alarm_ack = 1'b0;
    check("alarm_set_wins", 32'(alarm), 32'd1);
    alarm_ack = 1'b1; cycle(); alarm_ack = 1'b0;

    // pause
    do_load(24'h100000);
    repeat (2) cycle();
    run = 1'b0;
    repeat (10) cycle();
    check("pause_frozen", 32'(shown()), 32'h100000);
    run = 1'b1;
    cycle();
    check("resume_no_tick", 32'(tick), 32'd0);
    cycle();
    check("resume_tick", 32'(tick), 32'd1);
    check("resume_time", 32'(shown()), 32'h100001);

    // asynchronous reset mid-second
    cycle();
    mode_12h = 1'b1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_digits", 32'(shown()), 32'h120000);
    check_outputs();
    cycle();
    reset = 1'b0; mode_12h = 1'b0;

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      run       = ($urandom_range(0, 9) != 0);
      mode_12h  = $urandom_range(0, 1) == 1;
      alarm_en  = ($urandom_range(0, 5) != 0);
      alarm_ack = ($urandom_range(0, 14) == 0);
      load      = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) load_time = 24'($urandom);
      else load_time = enc($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(50, 59));
      alarm_wr  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) alarm_time = 16'($urandom);
      else begin
        int am = ((m_secs / 60) + 1) % 1440;
        alarm_time = enc(am / 60, am % 60, 0) >> 8;
      end
      cycle();
    end
    load = 1'b0; alarm_wr = 1'b0; alarm_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
